// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit synchronisers, selectable edge capture
// (write-1-to-clear), an interrupt mask and a registered level interrupt.
// Optional per-bit debounce is compiled in when PIO_DEBOUNCE_EN is defined.
module pio_in_edge_irq #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned PRIME_LEN = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_LEN + 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_CAP    = 2'd2;
    localparam logic [1:0] ADDR_CONFIG = 2'd3;

    logic [WIDTH-1:0]   sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0]   sync_in;
    logic [WIDTH-1:0]   data_val;
    logic [WIDTH-1:0]   prev_val;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   edge_evt;
    logic [WIDTH-1:0]   irq_mask;
    logic [WIDTH-1:0]   edge_cap;
    logic [WIDTH-1:0]   edge_cap_nxt;
    logic [1:0]         edge_sel;
    logic               wr_en;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    // Upper writedata bits are unused when WIDTH < 32
    assign unused_wdata = ^writedata;

    assign sync_in = sync_ff[SYNC_STAGES-1];
    assign primed  = (prime_cnt == PRIME_W'(PRIME_LEN));

    // Per-bit synchroniser chain for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

`ifdef PIO_DEBOUNCE_EN
    logic [15:0]      deb_cnt [WIDTH];
    logic [WIDTH-1:0] deb_val;

    assign data_val = deb_val;

    // Debounce: follow sync_in only after it has differed for DEBOUNCE_CYCLES cycles;
    // while priming, track sync_in directly so pins high at reset cause no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_val <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                deb_cnt[i] <= '0;
            end
        end else if (!primed) begin
            deb_val <= sync_in;
            for (int i = 0; i < int'(WIDTH); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync_in[i] != deb_val[i]) begin
                    if (32'(deb_cnt[i]) + 32'd1 >= DEBOUNCE_CYCLES) begin
                        deb_val[i] <= sync_in[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 16'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic [15:0] unused_deb_cfg;

    assign unused_deb_cfg = 16'(DEBOUNCE_CYCLES);
    assign data_val       = sync_in;
`endif

    // Prime counter and previous-value register for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
            prev_val  <= '0;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + PRIME_W'(1);
            end
            prev_val <= primed ? data_val : sync_in;
        end
    end

    // Edge select, sticky capture update and read mux
    always_comb begin
        wr_en        = chipselect & write;
        rise         = data_val & ~prev_val;
        fall         = ~data_val & prev_val;
        edge_evt     = '0;
        edge_cap_nxt = edge_cap;
        rd_mux       = '0;

        if (primed) begin
            case (edge_sel)
                2'd0:    edge_evt = rise;
                2'd1:    edge_evt = fall;
                default: edge_evt = rise | fall;
            endcase
        end

        if (wr_en && (address == ADDR_CAP)) begin
            edge_cap_nxt = edge_cap & ~writedata[WIDTH-1:0];
        end
        edge_cap_nxt = edge_cap_nxt | edge_evt;

        case (address)
            ADDR_DATA:   rd_mux = 32'(data_val);
            ADDR_MASK:   rd_mux = 32'(irq_mask);
            ADDR_CAP:    rd_mux = 32'(edge_cap);
            default:     rd_mux = 32'(edge_sel);
        endcase
    end

    // Control/status registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            edge_sel <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= edge_cap_nxt;
            if (wr_en && (address == ADDR_MASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (wr_en && (address == ADDR_CONFIG)) begin
                edge_sel <= writedata[1:0];
            end
            readdata <= rd_mux;
            irq      <= |(edge_cap & irq_mask);
        end
    end

endmodule
